offmem_responder: RTL and testbench
===================================

// Module: offmem_responder
// PURPOSE
//  Memory-side responder for the off-chip memory strobes (We/Re/Addr) that the accelerator's
//  off-chip interface issues with no backpressure.
//  Buffers each command, replays it as an Avalon-MM master transaction with waitrequest, and
//  returns read data in order with a valid strobe. Sits between the accelerator top and the board memory fabric.
// PARAMETERS
//  ADDR_WIDTH          32  word address width (matches off-chip interface address)
//  DATA_WIDTH          8   data word width
//  CMD_FIFO_DEPTH_LOG2 4   log2 command FIFO depth (16 entries)
//  MAX_PENDING_READS   8   max reads issued but not yet returned
// PORTS
//  OFMR_Clk               in  1          clock
//  OFMR_Reset             in  1          reset, asynchronous, active-low
//  OFMR_Offmem_We         in  1          write strobe, one command per cycle high
//  OFMR_Offmem_Re         in  1          read strobe, one command per cycle high
//  OFMR_Offmem_Addr       in  ADDR_WIDTH word address
//  OFMR_Offmem_Wdata      in  DATA_WIDTH write data, sampled with We
//  OFMR_Rdata             out DATA_WIDTH read data returned to datapath
//  OFMR_Rdata_Valid       out 1          OFMR_Rdata valid, one-cycle pulse per word
//  OFMR_Busy              out 1          FIFO non-empty, transaction in flight, or reads pending
//  OFMR_Error             out 1          sticky protocol/overflow error
//  OFMR_Error_Clr         in  1          synchronous clear of OFMR_Error
//  OFMR_Avm_Address       out ADDR_WIDTH Avalon address
//  OFMR_Avm_Read          out 1          Avalon read
//  OFMR_Avm_Write         out 1          Avalon write
//  OFMR_Avm_Writedata     out DATA_WIDTH Avalon write data
//  OFMR_Avm_Waitrequest   in  1          Avalon stall
//  OFMR_Avm_Readdata      in  DATA_WIDTH Avalon read data
//  OFMR_Avm_Readdatavalid in  1          Avalon read data valid
// BEHAVIOUR
//  Reset (OFMR_Reset=0, async):
//   - all outputs 0; FIFO emptied; pending count 0; FSM to IDLE.
//  Push: We|Re sampled at edge k writes {is_write, addr, wdata} to FIFO.
//   - We&Re same cycle: treated as write; Error set.
//   - Push while full with no pop at the same edge: command dropped; Error set.
//   - Push at full with a pop at the same edge: accepted.
//  FSM (output registers), two states IDLE, ISSUE:
//   - Issue condition: FIFO non-empty AND (head is write OR pending < MAX_PENDING_READS).
//   - IDLE: at edge k+1 after a push, if issue condition holds, pop head into Avm regs, go ISSUE.
//     Read/Write high from that edge (min push-to-bus latency 2 edges).
//   - ISSUE: hold Address/Read/Write/Writedata stable while Waitrequest=1.
//     Edge with Waitrequest=0 = accept. On accept, if issue condition holds, load next head
//     (back-to-back, stay ISSUE); else deassert Read/Write, go IDLE.
//  Pending reads (width clog2(MAX_PENDING_READS+1)):
//   - +1 on read accept, -1 on Readdatavalid; both at the same edge -> unchanged.
//   - Readdatavalid with pending=0 (incl. late response after reset): data discarded, Error set.
//  Return: Readdatavalid at edge j -> Rdata/Rdata_Valid registered, visible after edge j.
//   - 1-cycle latency, in order, no holding. Rdata holds last value when Valid=0.
//  OFMR_Busy: combinational OR of FIFO non-empty, FSM in ISSUE, pending != 0.
//  OFMR_Error: sticky until OFMR_Error_Clr; a clear and a new error at the same edge -> Error stays 1.
// CONFIGURATION
//  OFMR_BYTE_ADDR_EN defined:
//   - OFMR_Avm_Address = word address << clog2(DATA_WIDTH/8), truncated to ADDR_WIDTH.
//   - DATA_WIDTH must be a multiple of 8.
//  Undefined: word address passed through unchanged.
// STRUCTURE
//  offmem_defs.vh:
//   - FSM state localparams (IDLE=1'b0, ISSUE=1'b1).
//   - Command field offsets: CMD_WE bit, CMD_ADDR, CMD_DATA slices.
//   - CMD_WIDTH = 1+ADDR_WIDTH+DATA_WIDTH.
//  Sub-module offmem_cmd_fifo:
//   - Synchronous FIFO, width CMD_WIDTH, depth 2^CMD_FIFO_DEPTH_LOG2.
//   - Ports: push, pop, full, empty, head (first-word-fall-through), same-edge push/pop at full allowed.
// TESTING
//  1 Write, Waitrequest=0: We=1 Addr=0x100 Wdata=0x5A at edge 0.
//    -> Avm_Write=1 Addr=0x100 Data=0x5A after edge 1 for exactly one cycle; Busy falls after edge 2.
//  2 Stall: Re Addr=0x20 with Waitrequest=1 for 3 cycles.
//    -> Address/Read stable 4 cycles. Readdatavalid=1 Readdata=0xC3 -> Rdata=0xC3, Valid pulse next cycle.
//  3 Overflow: 17 consecutive Re with Waitrequest=1.
//    -> 16 queued, 17th dropped, Error=1. Error_Clr -> Error=0.
//  4 Pending limit: 10 reads, Waitrequest=0, no Readdatavalid.
//    -> exactly 8 reads issued, Read low. Two Readdatavalid -> remaining 2 issue.
//  5 Hazards: We&Re same cycle -> one write, Error=1. Readdatavalid with pending=0 -> no Rdata_Valid, Error=1.
//  6 Reset mid-burst: assert Reset with 5 queued.
//    -> all outputs 0 immediately. FIFO empty after release; late Readdatavalid flags Error.
//  Run 1-6 with and without OFMR_BYTE_ADDR_EN (DATA_WIDTH=32: Addr 0x100 -> Avm 0x400).

Source files
------------

// File: rtl/offmem_responder_pkg.sv
// Shared definitions for the off-chip memory responder: FSM state codes and
// the layout of a buffered command word {is_write, addr, wdata}.
package offmem_responder_pkg;

    // FSM state encodings (legacy-compatible constants)
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Write data occupies the least significant bits of a command word
    localparam int unsigned CMD_DATA_LSB = 0;

    // Total command word width: one write flag, the address, the data
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw;
    endfunction

    // Bit position of the is_write flag (MSB of the command word)
    function automatic int unsigned cmd_we_bit(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

    // LSB of the address slice, directly above the data slice
    function automatic int unsigned cmd_addr_lsb(input int unsigned dw);
        return dw;
    endfunction

endpackage

// File: rtl/offmem_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO. A push at full is
// accepted when a pop happens at the same edge.
module offmem_cmd_fifo #(
    parameter int unsigned WIDTH      = 41,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Storage array; no reset needed since entries are qualified by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/offmem_responder.sv
// Memory-side responder: buffers We/Re strobes from the off-chip interface,
// replays them as Avalon-MM transactions honouring waitrequest, and returns
// read data in order with a one-cycle valid pulse.
// Optional build macro: OFMR_BYTE_ADDR_EN (Avalon address in bytes instead
// of words; DATA_WIDTH must then be a multiple of 8).
module offmem_responder
    import offmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned CMD_FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned MAX_PENDING_READS   = 8
) (
    input  logic                  OFMR_Clk,
    input  logic                  OFMR_Reset,
    input  logic                  OFMR_Offmem_We,
    input  logic                  OFMR_Offmem_Re,
    input  logic [ADDR_WIDTH-1:0] OFMR_Offmem_Addr,
    input  logic [DATA_WIDTH-1:0] OFMR_Offmem_Wdata,
    output logic [DATA_WIDTH-1:0] OFMR_Rdata,
    output logic                  OFMR_Rdata_Valid,
    output logic                  OFMR_Busy,
    output logic                  OFMR_Error,
    input  logic                  OFMR_Error_Clr,
    output logic [ADDR_WIDTH-1:0] OFMR_Avm_Address,
    output logic                  OFMR_Avm_Read,
    output logic                  OFMR_Avm_Write,
    output logic [DATA_WIDTH-1:0] OFMR_Avm_Writedata,
    input  logic                  OFMR_Avm_Waitrequest,
    input  logic [DATA_WIDTH-1:0] OFMR_Avm_Readdata,
    input  logic                  OFMR_Avm_Readdatavalid
);

    localparam int unsigned CMD_W    = cmd_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned WE_BIT   = cmd_we_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned ADDR_LSB = cmd_addr_lsb(DATA_WIDTH);
    localparam int unsigned PEND_W   = $clog2(MAX_PENDING_READS + 1);

    logic [CMD_W-1:0]      cmd_in;
    logic [CMD_W-1:0]      head;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [0:0]            state;
    logic [PEND_W-1:0]     pending;
    logic [PEND_W-1:0]     pending_nxt;
    logic                  accept;
    logic                  read_accept;
    logic                  rsp_ok;
    logic                  issue_ok;
    logic                  err_set;

    // Simultaneous We and Re is stored as a write (We is the flag bit)
    assign push   = OFMR_Offmem_We | OFMR_Offmem_Re;
    assign cmd_in = {OFMR_Offmem_We, OFMR_Offmem_Addr, OFMR_Offmem_Wdata};

    offmem_cmd_fifo #(
        .WIDTH      (CMD_W),
        .DEPTH_LOG2 (CMD_FIFO_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk   (OFMR_Clk),
        .rst_n (OFMR_Reset),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_in),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_we   = head[WE_BIT];
    assign head_addr = head[ADDR_LSB +: ADDR_WIDTH];
    assign head_data = head[CMD_DATA_LSB +: DATA_WIDTH];

`ifdef OFMR_BYTE_ADDR_EN
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    assign bus_addr = head_addr << BYTE_SHIFT;
`else
    assign bus_addr = head_addr;
`endif

    assign accept      = (state == ST_ISSUE) && !OFMR_Avm_Waitrequest;
    assign read_accept = accept && OFMR_Avm_Read;
    // A response only counts when a read is actually outstanding
    assign rsp_ok      = OFMR_Avm_Readdatavalid && (pending != '0);

    // Pending-read count after this edge
    always_comb begin
        pending_nxt = pending;
        if (read_accept && !rsp_ok) begin
            pending_nxt = pending + PEND_W'(1);
        end else if (!read_accept && rsp_ok) begin
            pending_nxt = pending - PEND_W'(1);
        end
    end

    // The read limit is checked against the post-edge count so that a read
    // being accepted at this same edge already occupies a slot.
    assign issue_ok = !fifo_empty && (head_we || (pending_nxt < PEND_W'(MAX_PENDING_READS)));
    assign pop      = issue_ok && ((state == ST_IDLE) || accept);

    assign err_set = (OFMR_Offmem_We & OFMR_Offmem_Re) |
                     (push & fifo_full & !pop) |
                     (OFMR_Avm_Readdatavalid & (pending == '0));

    assign OFMR_Busy = !fifo_empty || (state == ST_ISSUE) || (pending != '0);

    // Issue FSM: load the Avalon registers from the FIFO head, hold under stall
    always_ff @(posedge OFMR_Clk or negedge OFMR_Reset) begin
        if (!OFMR_Reset) begin
            state              <= ST_IDLE;
            OFMR_Avm_Address   <= '0;
            OFMR_Avm_Read      <= 1'b0;
            OFMR_Avm_Write     <= 1'b0;
            OFMR_Avm_Writedata <= '0;
        end else if (pop) begin
            state              <= ST_ISSUE;
            OFMR_Avm_Address   <= bus_addr;
            OFMR_Avm_Read      <= !head_we;
            OFMR_Avm_Write     <= head_we;
            OFMR_Avm_Writedata <= head_data;
        end else if (accept) begin
            state          <= ST_IDLE;
            OFMR_Avm_Read  <= 1'b0;
            OFMR_Avm_Write <= 1'b0;
        end
    end

    // Outstanding read counter
    always_ff @(posedge OFMR_Clk or negedge OFMR_Reset) begin
        if (!OFMR_Reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Read data return register; data holds its last value between pulses
    always_ff @(posedge OFMR_Clk or negedge OFMR_Reset) begin
        if (!OFMR_Reset) begin
            OFMR_Rdata       <= '0;
            OFMR_Rdata_Valid <= 1'b0;
        end else begin
            OFMR_Rdata_Valid <= rsp_ok;
            if (rsp_ok) begin
                OFMR_Rdata <= OFMR_Avm_Readdata;
            end
        end
    end

    // Sticky error flag; a new error wins over a clear at the same edge
    always_ff @(posedge OFMR_Clk or negedge OFMR_Reset) begin
        if (!OFMR_Reset) begin
            OFMR_Error <= 1'b0;
        end else begin
            OFMR_Error <= err_set | (OFMR_Error & !OFMR_Error_Clr);
        end
    end

endmodule

// File: tb/tb_offmem_responder.sv
// Directed bench for offmem_responder with scoreboard queues for Avalon
// transactions and returned read data.
module tb_offmem_responder;

`ifdef OFMR_BYTE_ADDR_EN
    localparam int DW = 32;
    localparam int SH = 2;
`else
    localparam int DW = 8;
    localparam int SH = 0;
`endif

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] data;
    } bus_t;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic          re;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          busy;
    logic          error;
    logic          clr;
    logic [31:0]   avm_addr;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_wdata;
    logic          wait_req;
    logic [DW-1:0] rdata_in;
    logic          rdv;

    int errors = 0;
    int checks = 0;

    bus_t          exp_bus[$];
    logic [DW-1:0] exp_rd[$];

    offmem_responder #(
        .ADDR_WIDTH          (32),
        .DATA_WIDTH          (DW),
        .CMD_FIFO_DEPTH_LOG2 (4),
        .MAX_PENDING_READS   (8)
    ) dut (
        .OFMR_Clk               (clk),
        .OFMR_Reset             (rst_n),
        .OFMR_Offmem_We         (we),
        .OFMR_Offmem_Re         (re),
        .OFMR_Offmem_Addr       (addr),
        .OFMR_Offmem_Wdata      (wdata),
        .OFMR_Rdata             (rdata),
        .OFMR_Rdata_Valid       (rdata_valid),
        .OFMR_Busy              (busy),
        .OFMR_Error             (error),
        .OFMR_Error_Clr         (clr),
        .OFMR_Avm_Address       (avm_addr),
        .OFMR_Avm_Read          (avm_read),
        .OFMR_Avm_Write         (avm_write),
        .OFMR_Avm_Writedata     (avm_wdata),
        .OFMR_Avm_Waitrequest   (wait_req),
        .OFMR_Avm_Readdata      (rdata_in),
        .OFMR_Avm_Readdatavalid (rdv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs change and outputs are sampled here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    function automatic logic [31:0] xa(input logic [31:0] a);
        return a << SH;
    endfunction

    // Avalon monitor: a cycle with a request and no stall is an accept
    always @(negedge clk) begin
        if (rst_n && (avm_read || avm_write) && !wait_req) begin
            bus_t e;
            checks++;
            assert (exp_bus.size() != 0) else begin
                errors++;
                $error("FAIL bus_unexpected: observed write=%0b addr=%0h expected no transaction",
                       avm_write, avm_addr);
            end
            if (exp_bus.size() != 0) begin
                e = exp_bus.pop_front();
                chk("bus_kind", {63'd0, avm_write}, {63'd0, e.we});
                chk("bus_addr", {32'd0, avm_addr}, {32'd0, e.addr});
                if (e.we) chk("bus_wdata", 64'(avm_wdata), 64'(e.data));
            end
        end
    end

    // Read-return monitor
    always @(negedge clk) begin
        if (rst_n && rdata_valid) begin
            checks++;
            assert (exp_rd.size() != 0) else begin
                errors++;
                $error("FAIL rdata_unexpected: observed rdata=%0h expected no valid", rdata);
            end
            if (exp_rd.size() != 0) begin
                chk("rdata_value", 64'(rdata), 64'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        clr = 1'b0; wait_req = 1'b0; rdata_in = '0; rdv = 1'b0;
        cycles(2);
        chk("rst_read",  64'(avm_read), 0);
        chk("rst_write", 64'(avm_write), 0);
        chk("rst_addr",  64'(avm_addr), 0);
        chk("rst_busy",  64'(busy), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_valid", 64'(rdata_valid), 0);
        rst_n = 1'b1;
        cycles(2);

        // 1: single write, no stall
        we = 1'b1; addr = 32'h100; wdata = DW'(8'h5A);
        exp_bus.push_back('{1'b1, xa(32'h100), DW'(8'h5A)});
        cyc();
        we = 1'b0;
        chk("t1_write_e0", 64'(avm_write), 0);
        chk("t1_busy_e0",  64'(busy), 1);
        cyc();
        chk("t1_write_e1", 64'(avm_write), 1);
        chk("t1_addr",     64'(avm_addr), 64'(xa(32'h100)));
        chk("t1_wdata",    64'(avm_wdata), 64'h5A);
        cyc();
        chk("t1_write_e2", 64'(avm_write), 0);
        chk("t1_busy_e2",  64'(busy), 0);

        // 2: read held under three stalled cycles, then one response
        wait_req = 1'b1; re = 1'b1; addr = 32'h20;
        exp_bus.push_back('{1'b0, xa(32'h20), '0});
        cyc();
        re = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t2_read_hold", 64'(avm_read), 1);
            chk("t2_addr_hold", 64'(avm_addr), 64'(xa(32'h20)));
            if (i == 3) wait_req = 1'b0;
            cyc();
        end
        chk("t2_read_low",  64'(avm_read), 0);
        chk("t2_busy_pend", 64'(busy), 1);
        rdv = 1'b1; rdata_in = DW'(8'hC3);
        exp_rd.push_back(DW'(8'hC3));
        cyc();
        rdv = 1'b0;
        chk("t2_valid", 64'(rdata_valid), 1);
        chk("t2_rdata", 64'(rdata), 64'hC3);
        cyc();
        chk("t2_valid_low", 64'(rdata_valid), 0);
        chk("t2_rdata_hold", 64'(rdata), 64'hC3);
        chk("t2_busy_idle", 64'(busy), 0);

        // 3: overflow under stall. The first read moves onto the bus, the
        // next 16 fill the FIFO, so the 18th strobe is the one dropped.
        wait_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            re = 1'b1; addr = 32'h40 + 32'(i);
            if (i < 17) exp_bus.push_back('{1'b0, xa(32'h40 + 32'(i)), '0});
            cyc();
            if (i == 16) chk("t3_err_at_full", 64'(error), 0);
        end
        re = 1'b0;
        chk("t3_err_drop",  64'(error), 1);
        chk("t3_read_hold", 64'(avm_read), 1);
        chk("t3_addr_hold", 64'(avm_addr), 64'(xa(32'h40)));
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t3_err_clr", 64'(error), 0);
        wait_req = 1'b0;
        cyc();
        for (int i = 0; i < 17; i++) begin
            rdv = 1'b1; rdata_in = DW'(8'h10 + i);
            exp_rd.push_back(DW'(8'h10 + i));
            cyc();
        end
        rdv = 1'b0;
        cyc();
        chk("t3_drained_bus", 64'(exp_bus.size()), 0);
        chk("t3_drained_rd",  64'(exp_rd.size()), 0);
        chk("t3_busy",        64'(busy), 0);
        chk("t3_err_none",    64'(error), 0);

        // 4: pending-read limit
        for (int i = 0; i < 10; i++) begin
            re = 1'b1; addr = 32'h200 + 32'(i);
            exp_bus.push_back('{1'b0, xa(32'h200 + 32'(i)), '0});
            cyc();
        end
        re = 1'b0;
        cycles(4);
        chk("t4_read_low",  64'(avm_read), 0);
        chk("t4_left_over", 64'(exp_bus.size()), 2);
        chk("t4_busy",      64'(busy), 1);
        rdv = 1'b1; rdata_in = DW'(8'hA0); exp_rd.push_back(DW'(8'hA0));
        cyc();
        rdata_in = DW'(8'hA1); exp_rd.push_back(DW'(8'hA1));
        cyc();
        rdv = 1'b0;
        cycles(3);
        chk("t4_rest_issued", 64'(exp_bus.size()), 0);
        chk("t4_read_low2",   64'(avm_read), 0);
        for (int i = 0; i < 8; i++) begin
            rdv = 1'b1; rdata_in = DW'(8'hB0 + i);
            exp_rd.push_back(DW'(8'hB0 + i));
            cyc();
        end
        rdv = 1'b0;
        cyc();
        chk("t4_busy_done", 64'(busy), 0);
        chk("t4_err_none",  64'(error), 0);
        chk("t4_rd_empty",  64'(exp_rd.size()), 0);

        // 5: hazards
        we = 1'b1; re = 1'b1; addr = 32'h300; wdata = DW'(8'h77);
        exp_bus.push_back('{1'b1, xa(32'h300), DW'(8'h77)});
        cyc();
        we = 1'b0; re = 1'b0;
        chk("t5_both_err", 64'(error), 1);
        cycles(3);
        chk("t5_one_write", 64'(exp_bus.size()), 0);
        chk("t5_busy",      64'(busy), 0);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t5_err_clr", 64'(error), 0);
        rdv = 1'b1; rdata_in = DW'(8'hEE);
        cyc();
        rdv = 1'b0;
        chk("t5_stray_valid", 64'(rdata_valid), 0);
        chk("t5_stray_err",   64'(error), 1);
        chk("t5_rdata_hold",  64'(rdata), 64'hB7);
        clr = 1'b1; rdv = 1'b1;
        cyc();
        clr = 1'b0; rdv = 1'b0;
        chk("t5_clr_vs_set", 64'(error), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t5_err_clr2", 64'(error), 0);

        // 6: asynchronous reset with commands queued
        wait_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            re = 1'b1; addr = 32'h400 + 32'(i);
            cyc();
        end
        re = 1'b0;
        cyc();
        chk("t6_read_pre", 64'(avm_read), 1);
        chk("t6_busy_pre", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_read",  64'(avm_read), 0);
        chk("t6_rst_addr",  64'(avm_addr), 0);
        chk("t6_rst_busy",  64'(busy), 0);
        chk("t6_rst_rdata", 64'(rdata), 0);
        wait_req = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        chk("t6_post_read", 64'(avm_read), 0);
        chk("t6_post_busy", 64'(busy), 0);
        chk("t6_post_err",  64'(error), 0);
        rdv = 1'b1; rdata_in = DW'(8'h5A);
        cyc();
        rdv = 1'b0;
        chk("t6_late_valid", 64'(rdata_valid), 0);
        chk("t6_late_err",   64'(error), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t6_err_clr", 64'(error), 0);

        cycles(2);
        chk("end_bus_queue", 64'(exp_bus.size()), 0);
        chk("end_rd_queue",  64'(exp_rd.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
